color_checker: RTL
==================

COLOR_CHECKER -- requirements
Module: color_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 4, consecutive matching samples in VERIFY needed to enter LOCKED.
REQ-002 Parameter UNLOCK_THRESH, default 3, consecutive mismatching samples in LOCKED that force return to HUNT.
REQ-003 clk_referencia  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  received color byte from the pseudo-random color generator.
REQ-006 data_valid  input  1  data_in is sampled only when high at a rising edge.
REQ-007 clear_counts  input  1  synchronous clear of error_count and sample_count.
REQ-008 locked  output  1  high while state is LOCKED.
REQ-009 err  output  1  one-cycle pulse per mismatching valid sample in LOCKED.
REQ-010 error_count  output  16  saturating count of err pulses.
REQ-011 sample_count  output  32  valid samples seen (statistics option only).
REQ-012 state  output  2  HUNT=0, VERIFY=1, LOCKED=2; 3 unused.

Function
REQ-013 Sequence model: next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}; next(0x00) = 0x01 (lock-up escape).
REQ-014 Internal 8-bit register expected; 4-bit match counter; 4-bit miss counter.
REQ-015 No state change of any kind when data_valid is low.
REQ-016 HUNT + valid sample d: expected <= next(d), match counter <= 0, go VERIFY.
REQ-017 VERIFY + valid d == expected: expected <= next(d), match counter +1; go LOCKED when the count reaches LOCK_THRESH.
REQ-018 VERIFY + valid d != expected: reseed, expected <= next(d), match counter <= 0, stay VERIFY.
REQ-019 LOCKED + valid d == expected: expected <= next(d), miss counter <= 0, no err.
REQ-020 LOCKED + valid d != expected: err <= 1 next cycle, expected <= next(expected) (free-run), miss counter +1.
REQ-021 LOCKED: go HUNT when the miss counter reaches UNLOCK_THRESH; that same sample still pulses err.
REQ-022 locked, err and state are registered and reflect a sample one cycle after the edge that sampled it.
REQ-023 error_count saturates at 0xFFFF and does not wrap.
REQ-024 clear_counts has priority over a simultaneous increment: the count becomes 0, not 1.
REQ-025 clear_counts does not affect the state machine or expected.

Reset
REQ-026 reset low, asynchronously: state=HUNT, expected=0x00, both internal counters 0, locked=0, err=0, error_count=0, sample_count=0.
REQ-027 Reset asserted mid-lock discards lock immediately; after release, the first valid sample is treated as a HUNT seed.

Configuration
REQ-028 Macro COLOR_CHECKER_STATS_EN defined: sample_count increments by 1 per valid sample, wraps at 2^32, and is cleared by clear_counts.
REQ-029 Macro undefined: sample_count is tied to 0, no counter logic is present, and every other behaviour is unchanged.

Verification
REQ-030 Lock: after reset, valid samples 0x01, 0x02, 0x04, 0x08, 0x11 -> state goes VERIFY after 0x01; locked=1 one cycle after 0x11; err never asserted.
REQ-031 Single error: locked at expected 0x23, send 0x55 then 0x47 -> one err pulse; error_count=1; locked stays 1 (free-run expected 0x47 matches).
REQ-032 Unlock: locked, send three consecutive wrong bytes (0xAA, 0xAA, 0xAA) -> three err pulses; error_count=3; state=HUNT; locked=0 after the third.
REQ-033 VERIFY reseed: 0x01, 0x02, 0x99 -> state remains VERIFY; expected reseeded to next(0x99)=0x33; lock needs 4 more matches.
REQ-034 Saturation/clear: preload error_count to 0xFFFF via repeated errors -> an extra err leaves 0xFFFF; clear_counts together with an err -> error_count=0.
REQ-035 Async reset: assert reset between clock edges while locked -> locked=0 and error_count=0 without waiting for a clock edge; with COLOR_CHECKER_STATS_EN, sample_count=0.

Source files
------------

// File: rtl/color_checker.sv
// rtl/color_checker.sv - lock/verify checker for the 8-bit pseudo-random color sequence
// Optional sample statistics counter enabled by defining COLOR_CHECKER_STATS_EN.
module color_checker #(
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 3
) (
  input  logic        clk_referencia,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        clear_counts,
  output logic        locked,
  output logic        err,
  output logic [15:0] error_count,
  output logic [31:0] sample_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_T   = 4'(LOCK_THRESH);
  localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESH);

  state_t     cur_state;
  logic [7:0] expected;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic       is_match;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;
  logic       err_event;
  logic [7:0] next_from_data;
  logic [7:0] next_from_expected;

  // All-zero is the lock-up state of this shift sequence, so it is steered to 0x01.
  function automatic logic [7:0] next_color(input logic [7:0] x);
    logic [7:0] n;
    if (x == 8'h00) begin
      n = 8'h01;
    end else begin
      n = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    end
    return n;
  endfunction

  always_comb begin
    is_match           = (data_in == expected);
    match_inc          = match_cnt + 4'd1;
    miss_inc           = miss_cnt + 4'd1;
    next_from_data     = next_color(data_in);
    next_from_expected = next_color(expected);
    err_event          = data_valid && (cur_state == LOCKED) && !is_match;
  end

  assign state = cur_state;

  always_ff @(posedge clk_referencia or negedge reset) begin
    if (!reset) begin
      cur_state <= HUNT;
      expected  <= 8'h00;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (data_valid) begin
        case (cur_state)
          HUNT: begin
            expected  <= next_from_data;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            cur_state <= VERIFY;
            locked    <= 1'b0;
          end
          VERIFY: begin
            expected <= next_from_data;
            if (is_match) begin
              if (match_inc == LOCK_T) begin
                cur_state <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= 4'd0;
                miss_cnt  <= 4'd0;
              end else begin
                match_cnt <= match_inc;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (is_match) begin
              expected <= next_from_data;
              miss_cnt <= 4'd0;
            end else begin
              // Free-run on a miss so a single corrupted byte does not desync the checker.
              err      <= 1'b1;
              expected <= next_from_expected;
              if (miss_inc == UNLOCK_T) begin
                cur_state <= HUNT;
                locked    <= 1'b0;
                miss_cnt  <= 4'd0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end
          end
          default: begin
            cur_state <= HUNT;
            locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  // The count tracks err: it moves on the same edge that raises the pulse.
  always_ff @(posedge clk_referencia or negedge reset) begin
    if (!reset) begin
      error_count <= 16'h0000;
    end else if (clear_counts) begin
      error_count <= 16'h0000;
    end else if (err_event && (error_count != 16'hFFFF)) begin
      error_count <= error_count + 16'h0001;
    end
  end

`ifdef COLOR_CHECKER_STATS_EN
  always_ff @(posedge clk_referencia or negedge reset) begin
    if (!reset) begin
      sample_count <= 32'h0000_0000;
    end else if (clear_counts) begin
      sample_count <= 32'h0000_0000;
    end else if (data_valid) begin
      sample_count <= sample_count + 32'h0000_0001;
    end
  end
`else
  assign sample_count = 32'h0000_0000;
`endif

endmodule
